// File: rtl/traffic_nroad_if.sv
// Request/indication bundle between the intersection controller and its
// surroundings: emergency/pedestrian requests in, lamp drive and status out.
interface traffic_nroad_if #(
   parameter int NUM_ROADS = 3,
   parameter int RW        = $clog2(NUM_ROADS)
);
   logic                   emergency;
   logic [RW-1:0]          emg_road;
   logic                   ped_req;
   logic [3*NUM_ROADS-1:0] lights;
   logic                   ped_signal;
   logic [RW-1:0]          active_road;
   logic [2:0]             phase;

   modport master (
      output emergency, emg_road, ped_req,
      input  lights, ped_signal, active_road, phase
   );

   modport slave (
      input  emergency, emg_road, ped_req,
      output lights, ped_signal, active_road, phase
   );
endinterface

// File: rtl/traffic_nroad.sv
// N-road round-robin traffic-light controller with a latched pedestrian walk
// phase and emergency pre-emption using yellow/all-red clearance.
module traffic_nroad #(
   parameter int NUM_ROADS   = 3,
   parameter int GREEN_TIME  = 10,
   parameter int YELLOW_TIME = 3,
   parameter int ALLRED_TIME = 1,
   parameter int PED_TIME    = 5,
   parameter int CNT_W       = 8,
   parameter int RW          = $clog2(NUM_ROADS)
) (
   input logic            clk,
   input logic            reset_n,
   traffic_nroad_if.slave bus
);
   typedef enum logic [2:0] {
      PH_GREEN  = 3'd0,
      PH_YELLOW = 3'd1,
      PH_ALLRED = 3'd2,
      PH_PED    = 3'd3,
      PH_EMG    = 3'd4
   } phase_e;

   localparam logic [CNT_W-1:0] G_END   = CNT_W'(GREEN_TIME - 1);
   localparam logic [CNT_W-1:0] Y_END   = CNT_W'(YELLOW_TIME - 1);
   localparam logic [CNT_W-1:0] A_END   = CNT_W'(ALLRED_TIME - 1);
   localparam logic [CNT_W-1:0] P_END   = CNT_W'(PED_TIME - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [RW-1:0]    LAST_RD = RW'(NUM_ROADS - 1);

   phase_e                 phase_q, phase_d;
   logic [RW-1:0]          road_q, road_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   ped_pend_q, ped_pend_d;
   logic                   emg_lat_q;
   logic [RW-1:0]          emg_tgt_q, emg_tgt_d;
   logic [3*NUM_ROADS-1:0] lights_q;
   logic                   walk_q;

   logic                   emg_rise;
   logic [RW-1:0]          emg_road_c;
   logic [RW-1:0]          tgt_c;
   logic [RW-1:0]          road_nxt;

   // Out-of-range emergency targets fall back to road 0.
   function automatic logic [RW-1:0] clamp_road(input logic [RW-1:0] r);
      if ({1'b0, r} >= (RW+1)'(NUM_ROADS)) return '0;
      return r;
   endfunction

   function automatic logic [3*NUM_ROADS-1:0] decode_lights(input phase_e ph,
                                                            input logic [RW-1:0] rd);
      logic [3*NUM_ROADS-1:0] l;
      for (int i = 0; i < NUM_ROADS; i++) begin
         l[3*i +: 3] = 3'b100;
         if (rd == RW'(i)) begin
            if (ph == PH_GREEN || ph == PH_EMG) l[3*i +: 3] = 3'b001;
            else if (ph == PH_YELLOW)           l[3*i +: 3] = 3'b010;
         end
      end
      return l;
   endfunction

   // On the capture cycle the live emg_road is used; afterwards the latched one.
   assign emg_rise   = bus.emergency && !emg_lat_q;
   assign emg_road_c = clamp_road(bus.emg_road);
   assign tgt_c      = emg_rise ? emg_road_c : emg_tgt_q;
   assign road_nxt   = (road_q == LAST_RD) ? '0 : road_q + RW'(1);

   always_comb begin
      phase_d    = phase_q;
      road_d     = road_q;
      ped_pend_d = ped_pend_q | bus.ped_req;
      emg_tgt_d  = emg_rise ? emg_road_c : emg_tgt_q;

      case (phase_q)
         PH_GREEN: begin
            if (bus.emergency) phase_d = (road_q == tgt_c) ? PH_EMG : PH_YELLOW;
            else if (cnt_q == G_END) phase_d = PH_YELLOW;
         end
         PH_YELLOW: begin
            if (cnt_q == Y_END) begin
               phase_d = PH_ALLRED;
               road_d  = road_nxt;
            end
         end
         PH_ALLRED: begin
            if (cnt_q == A_END) begin
               if (bus.emergency) begin
                  phase_d = PH_EMG;
                  road_d  = tgt_c;
               end else if (ped_pend_q) begin
                  // The walk being started covers any request arriving now.
                  phase_d    = PH_PED;
                  ped_pend_d = 1'b0;
               end else begin
                  phase_d = PH_GREEN;
               end
            end
         end
         PH_PED: begin
            if (bus.emergency) begin
               phase_d    = PH_ALLRED;
               ped_pend_d = 1'b1;
            end else if (cnt_q == P_END) begin
               phase_d = PH_ALLRED;
            end
         end
         PH_EMG: begin
            if (!bus.emergency) phase_d = PH_YELLOW;
         end
         default: begin
            phase_d = PH_GREEN;
            road_d  = '0;
         end
      endcase

      if (phase_d != phase_q || road_d != road_q) cnt_d = '0;
      else if (phase_q == PH_EMG && cnt_q == CNT_MAX) cnt_d = cnt_q;
      else cnt_d = cnt_q + CNT_W'(1);
   end

   // Outputs are registered from the next state so they track the state register exactly.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_q    <= PH_GREEN;
         road_q     <= '0;
         cnt_q      <= '0;
         ped_pend_q <= 1'b0;
         emg_lat_q  <= 1'b0;
         emg_tgt_q  <= '0;
         lights_q   <= decode_lights(PH_GREEN, RW'(0));
         walk_q     <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         road_q     <= road_d;
         cnt_q      <= cnt_d;
         ped_pend_q <= ped_pend_d;
         emg_lat_q  <= bus.emergency;
         emg_tgt_q  <= emg_tgt_d;
         lights_q   <= decode_lights(phase_d, road_d);
         walk_q     <= (phase_d == PH_PED);
      end
   end

   assign bus.lights      = lights_q;
   assign bus.ped_signal  = walk_q;
   assign bus.active_road = road_q;
   assign bus.phase       = phase_q;
endmodule
